// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready pipeline stage with flush, ctrl zeroing on bubbles and perf counters.
// Optional skid register (registered in_ready) enabled by defining PIPE_STAGE_SKID_EN.
module pipe_stage_elastic #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              flush,
    input  logic              perf_clr,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

`ifdef PIPE_STAGE_SKID_EN
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
`else
    typedef enum logic {EMPTY, ONE} state_t;
`endif

    localparam logic [CNT_W+1:0] CNT_MAX = {2'b00, {CNT_W{1'b1}}};

    state_t            state_q, state_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
    logic [CNT_W-1:0]  stall_cnt_d, flush_cnt_d;
    logic [CNT_W+1:0]  flush_sum;
    logic [1:0]        held;
    logic              in_fire;
    logic              out_fire;

    assign out_valid = (state_q != EMPTY);
    assign out_data  = m_data_q;
    assign out_ctrl  = m_ctrl_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic [DATA_W-1:0] s_data_q, s_data_d;
    logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
    logic              in_ready_q;

    assign in_ready = in_ready_q;
    assign held     = (state_q == FULL) ? 2'd2 : {1'b0, out_valid};
`else
    assign in_ready = !out_valid | out_ready;
    assign held     = {1'b0, out_valid};
`endif

    always_comb begin
        state_d  = state_q;
        m_data_d = m_data_q;
        m_ctrl_d = m_ctrl_q;
`ifdef PIPE_STAGE_SKID_EN
        s_data_d = s_data_q;
        s_ctrl_d = s_ctrl_q;
`endif
        if (flush) begin
            state_d  = EMPTY;
            m_data_d = '0;
            m_ctrl_d = '0;
`ifdef PIPE_STAGE_SKID_EN
            s_data_d = '0;
            s_ctrl_d = '0;
`endif
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d  = ONE;
                        m_data_d = in_data;
                        m_ctrl_d = in_ctrl;
                    end
                end
                ONE: begin
                    if (in_fire && out_ready) begin
                        m_data_d = in_data;
                        m_ctrl_d = in_ctrl;
`ifdef PIPE_STAGE_SKID_EN
                    end else if (in_fire) begin
                        state_d  = FULL;
                        s_data_d = in_data;
                        s_ctrl_d = in_ctrl;
`endif
                    end else if (out_fire) begin
                        // Bubble: zero the ctrl so RegWrite/MemWrite cannot leak downstream.
                        state_d  = EMPTY;
                        m_data_d = '0;
                        m_ctrl_d = '0;
                    end
                end
`ifdef PIPE_STAGE_SKID_EN
                FULL: begin
                    if (out_ready) begin
                        state_d  = ONE;
                        m_data_d = s_data_q;
                        m_ctrl_d = s_ctrl_q;
                        s_data_d = '0;
                        s_ctrl_d = '0;
                    end
                end
`endif
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt;
        flush_cnt_d = flush_cnt;
        flush_sum   = {2'b00, flush_cnt} + {{CNT_W{1'b0}}, held}
                    + {{(CNT_W+1){1'b0}}, in_fire};
        if (perf_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (out_valid && !out_ready && (stall_cnt != '1))
                stall_cnt_d = stall_cnt + CNT_W'(1);
            // Discarded = held entries plus an input accepted in the flush cycle.
            if (flush)
                flush_cnt_d = (flush_sum > CNT_MAX) ? '1 : flush_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= EMPTY;
            m_data_q  <= '0;
            m_ctrl_q  <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state_q   <= state_d;
            m_data_q  <= m_data_d;
            m_ctrl_q  <= m_ctrl_d;
            stall_cnt <= stall_cnt_d;
            flush_cnt <= flush_cnt_d;
        end
    end

`ifdef PIPE_STAGE_SKID_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_data_q   <= '0;
            s_ctrl_q   <= '0;
            in_ready_q <= 1'b1;
        end else begin
            s_data_q   <= s_data_d;
            s_ctrl_q   <= s_ctrl_d;
            in_ready_q <= (state_d != FULL);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Self-checking bench for pipe_stage_elastic: directed vector table, counter saturation,
// and randomized traffic against a queue-based reference model.
module tb_pipe_stage_elastic;

`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif
    localparam int MAXC = 65535;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [31:0] in_ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [31:0] out_ctrl;
    logic        flush;
    logic        perf_clr;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] mq_d[$];
    logic [31:0] mq_c[$];
    int          m_stall = 0;
    int          m_flush = 0;

    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic [31:0] c;
        logic        ordy;
        logic        fl;
        logic        pc;
        logic        e_ov;
        logic [31:0] e_d;
        logic [31:0] e_c;
        logic        e_rdy;
        logic [15:0] e_st;
        logic [15:0] e_fl;
    } vec_t;

    vec_t vecs[$];

    pipe_stage_elastic #(.DATA_W(32), .CTRL_W(32), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .flush(flush), .perf_clr(perf_clr), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic iv, input logic [31:0] d, input logic [31:0] c,
                                input logic ordy, input logic fl, input logic pc,
                                input logic e_ov, input logic [31:0] e_d, input logic [31:0] e_c,
                                input logic e_rdy, input int e_st, input int e_fl);
        vec_t v;
        v.iv = iv; v.d = d; v.c = c; v.ordy = ordy; v.fl = fl; v.pc = pc;
        v.e_ov = e_ov; v.e_d = e_d; v.e_c = e_c; v.e_rdy = e_rdy;
        v.e_st = 16'(e_st); v.e_fl = 16'(e_fl);
        return v;
    endfunction

    // One clock: drive at negedge, optionally check against model, advance model, wait next negedge.
    task automatic cycle(input logic iv, input logic [31:0] d, input logic [31:0] c,
                         input logic ordy, input logic fl, input logic pc, input bit mchk);
        int sz;
        bit m_rdy, ifire, ofire;
        in_valid = iv; in_data = d; in_ctrl = c;
        out_ready = ordy; flush = fl; perf_clr = pc;
        #1;
        sz    = mq_d.size();
        m_rdy = SKID ? (sz < 2) : (sz == 0 || ordy);
        if (mchk) begin
            chk("rnd_out_valid", {31'b0, out_valid}, {31'b0, sz > 0});
            chk("rnd_out_data", out_data, (sz > 0) ? mq_d[0] : 32'h0);
            chk("rnd_out_ctrl", out_ctrl, (sz > 0) ? mq_c[0] : 32'h0);
            chk("rnd_in_ready", {31'b0, in_ready}, {31'b0, m_rdy});
            chk("rnd_stall_cnt", {16'b0, stall_cnt}, 32'(m_stall));
            chk("rnd_flush_cnt", {16'b0, flush_cnt}, 32'(m_flush));
        end
        ifire = iv && m_rdy;
        ofire = (sz > 0) && ordy;
        if (sz > 0 && !ordy && m_stall < MAXC) m_stall++;
        if (fl) begin
            m_flush = m_flush + sz + int'(ifire);
            if (m_flush > MAXC) m_flush = MAXC;
            mq_d.delete();
            mq_c.delete();
        end else begin
            if (ofire) begin
                void'(mq_d.pop_front());
                void'(mq_c.pop_front());
            end
            if (ifire) begin
                mq_d.push_back(d);
                mq_c.push_back(c);
            end
        end
        if (pc) begin
            m_stall = 0;
            m_flush = 0;
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_ctrl = '0;
        out_ready = 1'b0; flush = 1'b0; perf_clr = 1'b0;

        // Stream three entries
        vecs.push_back(mk(1, 32'h100, 32'h1, 1, 0, 0,   1, 32'h100, 32'h1, 1, 0, 0));
        vecs.push_back(mk(1, 32'h104, 32'h1, 1, 0, 0,   1, 32'h104, 32'h1, 1, 0, 0));
        vecs.push_back(mk(1, 32'h108, 32'h1, 1, 0, 0,   1, 32'h108, 32'h1, 1, 0, 0));
        vecs.push_back(mk(0, 32'h0,   32'h0, 1, 0, 0,   0, 32'h0,   32'h0, 1, 0, 0));
        // Hold 0x200 for 4 stall cycles, then release
        vecs.push_back(mk(1, 32'h200, 32'h3, 0, 0, 0,   1, 32'h200, 32'h3, SKID, 0, 0));
        vecs.push_back(mk(0, 32'h0,   32'h0, 0, 0, 0,   1, 32'h200, 32'h3, SKID, 1, 0));
        vecs.push_back(mk(0, 32'h0,   32'h0, 0, 0, 0,   1, 32'h200, 32'h3, SKID, 2, 0));
        vecs.push_back(mk(0, 32'h0,   32'h0, 0, 0, 0,   1, 32'h200, 32'h3, SKID, 3, 0));
        vecs.push_back(mk(0, 32'h0,   32'h0, 0, 0, 0,   1, 32'h200, 32'h3, SKID, 4, 0));
        vecs.push_back(mk(0, 32'h0,   32'h0, 1, 0, 0,   0, 32'h0,   32'h0, 1, 4, 0));
        // Flush while holding one entry and accepting 0x300
        vecs.push_back(mk(1, 32'h2FC, 32'h1, 0, 0, 0,   1, 32'h2FC, 32'h1, SKID, 4, 0));
        vecs.push_back(mk(1, 32'h300, 32'h3, 1, 1, 0,   0, 32'h0,   32'h0, 1, 4, 2));
        vecs.push_back(mk(0, 32'h0,   32'h0, 1, 0, 0,   0, 32'h0,   32'h0, 1, 4, 2));
        // Flush together with perf_clr
        vecs.push_back(mk(1, 32'h400, 32'h3, 0, 0, 0,   1, 32'h400, 32'h3, SKID, 4, 2));
        vecs.push_back(mk(0, 32'h0,   32'h0, 0, 1, 1,   0, 32'h0,   32'h0, 1, 0, 0));
`ifdef PIPE_STAGE_SKID_EN
        // Skid: fill both slots, drain back-to-back, then flush from FULL
        vecs.push_back(mk(1, 32'hA,   32'h1, 0, 0, 0,   1, 32'hA,   32'h1, 1, 0, 0));
        vecs.push_back(mk(1, 32'hB,   32'h2, 0, 0, 0,   1, 32'hA,   32'h1, 0, 1, 0));
        vecs.push_back(mk(0, 32'h0,   32'h0, 1, 0, 0,   1, 32'hB,   32'h2, 1, 1, 0));
        vecs.push_back(mk(0, 32'h0,   32'h0, 1, 0, 0,   0, 32'h0,   32'h0, 1, 1, 0));
        vecs.push_back(mk(1, 32'hC,   32'h3, 0, 0, 0,   1, 32'hC,   32'h3, 1, 1, 0));
        vecs.push_back(mk(1, 32'hD,   32'h3, 0, 0, 0,   1, 32'hC,   32'h3, 0, 2, 0));
        vecs.push_back(mk(1, 32'hE,   32'h3, 0, 1, 0,   0, 32'h0,   32'h0, 1, 3, 2));
`endif

        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_ctrl", out_ctrl, 32'h0);
        chk("rst_stall_cnt", {16'b0, stall_cnt}, 32'h0);
        chk("rst_flush_cnt", {16'b0, flush_cnt}, 32'h0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'h1);

        foreach (vecs[i]) begin
            cycle(vecs[i].iv, vecs[i].d, vecs[i].c, vecs[i].ordy, vecs[i].fl, vecs[i].pc, 1'b0);
            chk($sformatf("vec%0d_out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].e_ov});
            chk($sformatf("vec%0d_out_data", i), out_data, vecs[i].e_d);
            chk($sformatf("vec%0d_out_ctrl", i), out_ctrl, vecs[i].e_c);
            chk($sformatf("vec%0d_in_ready", i), {31'b0, in_ready}, {31'b0, vecs[i].e_rdy});
            chk($sformatf("vec%0d_stall_cnt", i), {16'b0, stall_cnt}, {16'b0, vecs[i].e_st});
            chk($sformatf("vec%0d_flush_cnt", i), {16'b0, flush_cnt}, {16'b0, vecs[i].e_fl});
        end

        // stall_cnt saturation and perf_clr
        cycle(0, 32'h0, 32'h0, 0, 1, 1, 1'b0);
        cycle(1, 32'h500, 32'h3, 0, 0, 0, 1'b0);
        chk("sat_start", {16'b0, stall_cnt}, 32'h0);
        for (int i = 0; i < MAXC; i++) cycle(0, 32'h0, 32'h0, 0, 0, 0, 1'b0);
        chk("sat_reach", {16'b0, stall_cnt}, 32'hFFFF);
        for (int i = 0; i < 3; i++) cycle(0, 32'h0, 32'h0, 0, 0, 0, 1'b0);
        chk("sat_hold", {16'b0, stall_cnt}, 32'hFFFF);
        chk("sat_data_stable", out_data, 32'h500);
        cycle(0, 32'h0, 32'h0, 0, 0, 1, 1'b0);
        chk("sat_clr", {16'b0, stall_cnt}, 32'h0);
        chk("sat_clr_valid", {31'b0, out_valid}, 32'h1);
        cycle(0, 32'h0, 32'h0, 1, 0, 0, 1'b0);
        chk("sat_drain", {31'b0, out_valid}, 32'h0);

        // Randomized traffic against the queue model
        for (int i = 0; i < 2000; i++) begin
            cycle(($urandom_range(99) < 70), $urandom, $urandom,
                  ($urandom_range(99) < 60), ($urandom_range(99) < 5),
                  ($urandom_range(99) < 2), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
